// File: rtl/nibble_byte_packer.sv
// nibble_byte_packer
//
// Pairs a stream of 4-bit nibbles into 8-bit bytes. A small FIFO buffers the
// completed bytes. Each byte is stored with its even-parity bit and a flag
// that marks a zero-padded byte built from a single flushed nibble.
//
// Ports:
//   clk         sole clock, rising edge
//   rst         synchronous active-high reset
//   in_valid    nibble offered
//   in_ready    packer can accept a nibble (registered count only)
//   in_nib      nibble data
//   in_flush    with an EMPTY-state accept, emit the nibble zero-padded
//   out_valid   FIFO head valid
//   out_ready   downstream accepts the head
//   out_byte    FIFO head byte
//   out_par     even-parity bit (^out_byte) of the head entry
//   out_padded  head byte came from a flushed lone nibble
//   out_held    a nibble is held waiting for its partner
//
// States:
//   state    | meaning
//   ---------+--------------------------------------------
//   ST_EMPTY | no nibble held; next nibble starts a pair
//   ST_HALF  | one nibble held in hold_q; next nibble completes the byte
module nibble_byte_packer #(
    parameter int LSN_FIRST = 1,
    parameter int OUT_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_nib,
    input  logic       in_flush,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_byte,
    output logic       out_par,
    output logic       out_padded,
    output logic       out_held
);

    localparam int AW = $clog2(OUT_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(OUT_DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HALF  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      hold_q, hold_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      mem_byte_q [OUT_DEPTH];
    logic [7:0]      mem_byte_d [OUT_DEPTH];
    logic            mem_par_q  [OUT_DEPTH];
    logic            mem_par_d  [OUT_DEPTH];
    logic            mem_pad_q  [OUT_DEPTH];
    logic            mem_pad_d  [OUT_DEPTH];

    logic            accept;
    logic            pop;
    logic            push;
    logic [7:0]      push_byte;
    logic            push_pad;

    // Full is decided from the registered count alone, so a pop in the same
    // cycle does not open the input; this keeps out_ready off the in_ready path.
    assign in_ready   = !rst && (count_q != FULL_CNT);
    assign out_valid  = (count_q != '0);
    assign out_byte   = mem_byte_q[rd_ptr_q];
    assign out_par    = mem_par_q[rd_ptr_q];
    assign out_padded = mem_pad_q[rd_ptr_q];
    assign out_held   = (state_q == ST_HALF);

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        mem_byte_d = mem_byte_q;
        mem_par_d  = mem_par_q;
        mem_pad_d  = mem_pad_q;
        push       = 1'b0;
        push_byte  = 8'h00;
        push_pad   = 1'b0;

        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    if (in_flush) begin
                        push     = 1'b1;
                        push_pad = 1'b1;
                        if (LSN_FIRST != 0) push_byte = {4'h0, in_nib};
                        else                push_byte = {in_nib, 4'h0};
                    end else begin
                        hold_d  = in_nib;
                        state_d = ST_HALF;
                    end
                end
            end
            ST_HALF: begin
                // A flush on the completing nibble has nothing to pad.
                if (accept) begin
                    push    = 1'b1;
                    state_d = ST_EMPTY;
                    if (LSN_FIRST != 0) push_byte = {in_nib, hold_q};
                    else                push_byte = {hold_q, in_nib};
                end
            end
        endcase

        if (push) begin
            mem_byte_d[wr_ptr_q] = push_byte;
            mem_par_d[wr_ptr_q]  = ^push_byte;
            mem_pad_d[wr_ptr_q]  = push_pad;
            wr_ptr_d             = wr_ptr_q + PTR_ONE;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            hold_q   <= 4'h0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                mem_byte_q[i] <= 8'h00;
                mem_par_q[i]  <= 1'b0;
                mem_pad_q[i]  <= 1'b0;
            end
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            mem_byte_q <= mem_byte_d;
            mem_par_q  <= mem_par_d;
            mem_pad_q  <= mem_pad_d;
        end
    end

endmodule
